fdc_disk_responder: RTL and testbench

FDC_DISK_RESPONDER -- requirements
Module: fdc_disk_responder

---
 rtl/fdc_disk_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fdc_disk_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_disk_responder.sv
// Floppy image responder: serves seek, read-ID, sector read and sector write
// requests from the FDC core against a byte-wide image memory, one image per drive.
module fdc_disk_responder #(
  parameter int unsigned TRACKS     = 42,
  parameter int unsigned SPT        = 9,
  parameter logic [7:0]  FIRST_SECT = 8'hC1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disk_sr,
  output logic [31:0] disk_cr,
  output logic [7:0]  disk_data_in,
  output logic        disk_data_clkin,
  input  logic [7:0]  disk_data_out,
  output logic        disk_data_clkout,
  input  logic [1:0]  disk_inserted,
  input  logic [1:0]  disk_wp,
  output logic [19:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned LBA_W = 10;
  localparam logic [CNT_W-1:0] SECT_BYTES = CNT_W'(512);

  typedef enum logic [3:0] {
    IDLE, DECODE, SEEK, RID, RD_MEM, RD_PUSH, WR_POP, WR_MEM, DONE, WAIT_ACK
  } state_t;

  typedef enum logic [1:0] {OP_SEEK, OP_RID, OP_RD, OP_WR} op_t;

  state_t               state_q, state_d;
  op_t                  op_q, op_d, req_op;
  logic                 drive_q, drive_d, req_drive;
  logic                 head_q, head_d;
  logic [6:0]           cyl_q, cyl_d;
  logic [7:0]           sect_q, sect_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0][7:0]      rot_q, rot_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 wperr_q, wperr_d;
  logic [1:0]           seek_q, seek_d;
  logic [7:0]           cr_sect_q, cr_sect_d;
  logic                 cr_head_q, cr_head_d;
  logic [7:0]           data_in_d;
  logic                 clkin_d, clkout_d;
  logic [19:0]          addr_d;
  logic                 rd_d, wr_d;
  logic [7:0]           wdata_d;

  logic                 req_any, ack_seen;
  logic                 cyl_bad, sect_ok, bad_req;
  logic [LBA_W-1:0]     lba;
  logic [19:0]          byte_addr;
  logic                 unused_sr_bits;

  assign unused_sr_bits = ^disk_sr[22:16];

  assign req_any  = |disk_sr[31:24];
  assign ack_seen = disk_sr[23] && (disk_sr[31:24] == 8'h00);

  // Request arbitration: seek > readid > readsect > write, drive 0 before drive 1.
  always_comb begin
    req_op    = OP_SEEK;
    req_drive = 1'b0;
    if (disk_sr[30]) begin
      req_op = OP_SEEK; req_drive = 1'b0;
    end else if (disk_sr[31]) begin
      req_op = OP_SEEK; req_drive = 1'b1;
    end else if (disk_sr[28]) begin
      req_op = OP_RID;  req_drive = 1'b0;
    end else if (disk_sr[29]) begin
      req_op = OP_RID;  req_drive = 1'b1;
    end else if (disk_sr[24]) begin
      req_op = OP_RD;   req_drive = 1'b0;
    end else if (disk_sr[25]) begin
      req_op = OP_RD;   req_drive = 1'b1;
    end else if (disk_sr[26]) begin
      req_op = OP_WR;   req_drive = 1'b0;
    end else begin
      req_op = OP_WR;   req_drive = 1'b1;
    end
  end

  assign cyl_bad = 32'(cyl_q) >= TRACKS;
  assign sect_ok = (sect_q >= FIRST_SECT) && ({1'b0, sect_q} < (9'(FIRST_SECT) + 9'(SPT)));
  assign bad_req = !disk_inserted[drive_q] || cyl_bad ||
                   (((op_q == OP_RD) || (op_q == OP_WR)) && !sect_ok);

  // Linear sector index within the image; byte offset is lba*512 + byte index.
  assign lba       = LBA_W'((32'(cyl_q) * 32'd2 + 32'(head_q)) * SPT + 32'(sect_q - FIRST_SECT));
  assign byte_addr = {drive_q, lba, cnt_q[8:0]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    drive_d   = drive_q;
    head_d    = head_q;
    cyl_d     = cyl_q;
    sect_d    = sect_q;
    cnt_d     = cnt_q;
    rot_d     = rot_q;
    done_d    = done_q;
    err_d     = err_q;
    wperr_d   = wperr_q;
    seek_d    = seek_q;
    cr_sect_d = cr_sect_q;
    cr_head_d = cr_head_q;
    data_in_d = disk_data_in;
    clkin_d   = 1'b0;
    clkout_d  = 1'b0;
    addr_d    = mem_addr;
    rd_d      = mem_rd;
    wr_d      = mem_wr;
    wdata_d   = mem_wdata;

    unique case (state_q)
      IDLE: begin
        if (req_any && !disk_sr[23]) begin
          state_d = DECODE;
          op_d    = req_op;
          drive_d = req_drive;
          head_d  = disk_sr[15];
          cyl_d   = disk_sr[14:8];
          sect_d  = disk_sr[7:0];
          cnt_d   = '0;
        end
      end
      DECODE: begin
        if (bad_req) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if ((op_q == OP_WR) && disk_wp[drive_q]) begin
          err_d   = 1'b1;
          wperr_d = 1'b1;
          state_d = DONE;
        end else begin
          unique case (op_q)
            OP_SEEK: state_d = SEEK;
            OP_RID:  state_d = RID;
            OP_RD: begin
              state_d = RD_MEM;
              rd_d    = 1'b1;
              addr_d  = byte_addr;
            end
            default: state_d = WR_POP;
          endcase
        end
      end
      SEEK: begin
        seek_d[drive_q] = 1'b1;
        state_d         = DONE;
      end
      RID: begin
        sect_d         = FIRST_SECT + rot_q[drive_q];
        rot_d[drive_q] = (32'(rot_q[drive_q]) == SPT - 1) ? 8'h00 : rot_q[drive_q] + 8'h01;
        state_d        = DONE;
      end
      RD_MEM: begin
        if (mem_ready) begin
          rd_d      = 1'b0;
          data_in_d = mem_rdata;
          clkin_d   = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = RD_PUSH;
        end
      end
      RD_PUSH: begin
        if (cnt_q == SECT_BYTES) begin
          state_d = DONE;
        end else begin
          rd_d    = 1'b1;
          addr_d  = byte_addr;
          state_d = RD_MEM;
        end
      end
      WR_POP: begin
        wdata_d  = disk_data_out;
        clkout_d = 1'b1;
        wr_d     = 1'b1;
        addr_d   = byte_addr;
        state_d  = WR_MEM;
      end
      WR_MEM: begin
        // Returning through WR_POP guarantees a low cycle between pop strobes.
        if (mem_ready) begin
          wr_d    = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ((cnt_q + CNT_W'(1)) == SECT_BYTES) ? DONE : WR_POP;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        cr_sect_d = sect_q;
        cr_head_d = head_q;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_seen) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          wperr_d = 1'b0;
          seek_d  = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      op_q             <= OP_SEEK;
      drive_q          <= 1'b0;
      head_q           <= 1'b0;
      cyl_q            <= '0;
      sect_q           <= '0;
      cnt_q            <= '0;
      rot_q            <= '0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      wperr_q          <= 1'b0;
      seek_q           <= 2'b00;
      cr_sect_q        <= '0;
      cr_head_q        <= 1'b0;
      disk_data_in     <= '0;
      disk_data_clkin  <= 1'b0;
      disk_data_clkout <= 1'b0;
      mem_addr         <= '0;
      mem_rd           <= 1'b0;
      mem_wr           <= 1'b0;
      mem_wdata        <= '0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      drive_q          <= drive_d;
      head_q           <= head_d;
      cyl_q            <= cyl_d;
      sect_q           <= sect_d;
      cnt_q            <= cnt_d;
      rot_q            <= rot_d;
      done_q           <= done_d;
      err_q            <= err_d;
      wperr_q          <= wperr_d;
      seek_q           <= seek_d;
      cr_sect_q        <= cr_sect_d;
      cr_head_q        <= cr_head_d;
      disk_data_in     <= data_in_d;
      disk_data_clkin  <= clkin_d;
      disk_data_clkout <= clkout_d;
      mem_addr         <= addr_d;
      mem_rd           <= rd_d;
      mem_wr           <= wr_d;
      mem_wdata        <= wdata_d;
    end
  end

  assign disk_cr = {cr_sect_q, 8'h00, 7'h00, cr_head_q, 1'b0, disk_inserted,
                    done_q, err_q, wperr_q, seek_q};

endmodule

// File: tb/tb_fdc_disk_responder.sv
// Scoreboard bench for fdc_disk_responder: requests are modelled at issue time,
// and a negedge monitor checks every strobe, memory access and completion.
module tb_fdc_disk_responder;

  localparam int          TRACKS     = 42;
  localparam int          SPT        = 9;
  localparam int          FIRST      = 8'hC1;
  localparam int          DONE_LIMIT = 8000;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] disk_sr = '0;
  logic [31:0] disk_cr;
  logic [7:0]  disk_data_in;
  logic        disk_data_clkin;
  logic [7:0]  disk_data_out = '0;
  logic        disk_data_clkout;
  logic [1:0]  inserted = 2'b11;
  logic [1:0]  wp = 2'b00;
  logic [19:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ready = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          clkin_cnt = 0;
  int          ready_mode = 0;
  int          rot[2] = '{0, 0};
  logic        prev_done = 1'b0;

  xfer_t       exp_rd[$];
  xfer_t       exp_wr[$];
  logic [7:0]  wfifo[$];
  logic [31:0] exp_done[$];

  fdc_disk_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .disk_sr          (disk_sr),
    .disk_cr          (disk_cr),
    .disk_data_in     (disk_data_in),
    .disk_data_clkin  (disk_data_clkin),
    .disk_data_out    (disk_data_out),
    .disk_data_clkout (disk_data_clkout),
    .disk_inserted    (inserted),
    .disk_wp          (wp),
    .mem_addr         (mem_addr),
    .mem_rd           (mem_rd),
    .mem_wr           (mem_wr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ready        (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[11:8]} ^ 8'h3C;
  endfunction

  assign mem_rdata = mem_byte(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory handshake: random or every third cycle.
  initial begin
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      mem_ready = (ready_mode == 1) ? (n % 3 == 0) : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare everything the DUT presents against the expectation queues.
  initial begin
    xfer_t x;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        note(!mem_wr, "rd_wr_exclusive", 32'(mem_wr), 0);
        note(exp_rd.size() != 0, "mem_rd_unexpected", 32'(mem_addr), 0);
        if (mem_ready && exp_rd.size() != 0) check("rd_addr", 32'(mem_addr), 32'(exp_rd[0].addr));
      end
      if (disk_data_clkin) begin
        clkin_cnt++;
        if (exp_rd.size() == 0) note(1'b0, "clkin_unexpected", 32'(disk_data_in), 0);
        else begin
          x = exp_rd.pop_front();
          check("rd_byte", 32'(disk_data_in), 32'(x.data));
        end
      end
      if (mem_wr && mem_ready) begin
        if (exp_wr.size() == 0) note(1'b0, "mem_wr_unexpected", 32'(mem_addr), 0);
        else begin
          x = exp_wr.pop_front();
          check("wr_addr_data", {4'h0, mem_addr, mem_wdata}, {4'h0, x.addr, x.data});
        end
      end
      if (disk_data_clkout) begin
        if (wfifo.size() == 0) note(1'b0, "clkout_unexpected", 1, 0);
        else begin
          void'(wfifo.pop_front());
          disk_data_out = (wfifo.size() != 0) ? wfifo[0] : 8'h00;
        end
      end
      if (disk_cr[4] && !prev_done) begin
        if (exp_done.size() == 0) note(1'b0, "done_unexpected", disk_cr, 0);
        else begin
          e = exp_done.pop_front();
          check("done_cr", disk_cr & ~32'h60, e);
        end
      end
      prev_done = disk_cr[4];
    end
  end

  // Reference model: resolve the request by priority table and queue its effects.
  task automatic issue(input logic [7:0] req, input logic head, input logic [6:0] cyl, input logic [7:0] sect);
    int prio[8] = '{30, 31, 28, 29, 24, 25, 26, 27};
    int op = 0, drv = 0, base, s;
    logic err, wpe;
    logic [7:0] rsect, b;
    logic [1:0] sk;
    logic [19:0] a;
    for (int k = 7; k >= 0; k--)
      if (req[prio[k] - 24]) begin op = k / 2; drv = k % 2; end
    s = int'(sect);
    rsect = sect;
    err = !inserted[drv] || (int'(cyl) >= TRACKS) || ((op >= 2) && (s < FIRST || s >= FIRST + SPT));
    wpe = !err && (op == 3) && wp[drv];
    if (wpe) err = 1'b1;
    sk = 2'b00;
    if (op == 0 && !err) sk[drv] = 1'b1;
    if (op == 1 && !err) begin
      rsect = 8'(FIRST + rot[drv]);
      rot[drv] = (rot[drv] + 1) % SPT;
    end
    if (!err && op >= 2) begin
      base = ((int'(cyl) * 2 + int'(head)) * SPT + (s - FIRST)) * 512;
      for (int i = 0; i < 512; i++) begin
        a = {1'(drv), 19'(base + i)};
        if (op == 2) exp_rd.push_back('{a, mem_byte(a)});
        else begin
          b = 8'($urandom);
          wfifo.push_back(b);
          exp_wr.push_back('{a, b});
        end
      end
      if (op == 3) disk_data_out = wfifo[0];
    end
    exp_done.push_back({rsect, 8'h00, 7'h00, head, 1'b0, 2'b00, 1'b1, err, wpe, sk});
  endtask

  task automatic flush_model();
    exp_rd.delete();
    exp_wr.delete();
    wfifo.delete();
    exp_done.delete();
    disk_data_out = 8'h00;
  endtask

  task automatic run_op(input logic [7:0] req, input logic head, input logic [6:0] cyl, input logic [7:0] sect);
    int n = 0;
    issue(req, head, cyl, sect);
    @(posedge clk);
    #1;
    disk_sr = {req, 1'b0, 7'h00, head, cyl, sect};
    while (!disk_cr[4] && n < DONE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    note(disk_cr[4] === 1'b1, "done_within_budget", 32'(n), 32'(DONE_LIMIT));
    check("cr_inserted_mirror", 32'(disk_cr[6:5]), 32'(inserted));
    @(posedge clk);
    #1;
    disk_sr = 32'h0080_0000;
    @(posedge clk);
    #1;
    check("ack_clears_status", 32'(disk_cr[4:0]), 0);
    disk_sr = '0;
    check("queues_drained", 32'(exp_rd.size() + exp_wr.size() + wfifo.size() + exp_done.size()), 0);
    flush_model();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, n;
    logic [7:0] req;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cr", disk_cr & ~32'h60, 0);
    check("reset_mirror", 32'(disk_cr[6:5]), 32'(inserted));
    check("reset_outputs", {20'h0, disk_data_clkin, disk_data_clkout, mem_rd, mem_wr, disk_data_in}, 0);
    rst_n = 1'b1;

    run_op(8'h40, 1'b0, 7'd5, 8'hC1);            // seek drv0 cyl 5
    ready_mode = 1;
    run_op(8'h01, 1'b0, 7'd1, 8'hC3);            // read drv0 c1 h0 C3
    ready_mode = 0;
    run_op(8'h01, 1'b0, 7'd1, 8'hCA);            // sector past the track
    run_op(8'h01, 1'b1, 7'd4, 8'hC0);            // sector below the track
    run_op(8'h01, 1'b1, 7'd41, 8'hC9);           // last cylinder, last sector
    wp = 2'b10;
    run_op(8'h08, 1'b1, 7'd3, 8'hC4);            // write drv1 protected
    wp = 2'b00;
    run_op(8'h08, 1'b1, 7'd3, 8'hC4);            // write drv1
    for (int i = 0; i < 10; i++) run_op(8'h10, 1'b0, 7'd0, 8'h00);
    run_op(8'h50, 1'b0, 7'd2, 8'h00);            // seek beats readid
    run_op(8'h30, 1'b1, 7'd2, 8'h00);            // readid drv0 beats drv1
    run_op(8'h0A, 1'b0, 7'd6, 8'hC2);            // readsect drv1 beats write drv1
    run_op(8'h40, 1'b0, 7'd42, 8'hC1);           // cylinder out of range
    inserted = 2'b01;
    run_op(8'h80, 1'b0, 7'd3, 8'hC1);            // drive 1 empty
    inserted = 2'b11;

    // Abort a read partway through the sector.
    issue(8'h01, 1'b1, 7'd2, 8'hC5);
    @(posedge clk);
    #1;
    disk_sr = {8'h01, 1'b0, 7'h00, 1'b1, 7'd2, 8'hC5};
    c0 = clkin_cnt;
    n = 0;
    while (clkin_cnt - c0 < 200 && n < DONE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    note(clkin_cnt - c0 >= 200, "reach_byte_200", 32'(clkin_cnt - c0), 200);
    rst_n = 1'b0;
    disk_sr = '0;
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs", {20'h0, disk_data_clkin, disk_data_clkout, mem_rd, mem_wr, disk_data_in}, 0);
    check("abort_cr", disk_cr & ~32'h60, 0);
    flush_model();
    rot = '{0, 0};
    rst_n = 1'b1;
    run_op(8'h01, 1'b1, 7'd2, 8'hC5);
    run_op(8'h20, 1'b0, 7'd0, 8'h00);            // readid drv1 restarts at C1

    for (int t = 0; t < 16; t++) begin
      inserted   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      wp         = 2'($urandom) & 2'($urandom);
      ready_mode = int'($urandom_range(0, 1));
      req        = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req = req | 8'($urandom);
      run_op(req, 1'($urandom), 7'($urandom_range(0, 45)), 8'(8'hC0 + $urandom_range(0, 10)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
